// File: rtl/apb_req_arbiter_pkg.sv
// Shared constants and types for the APB request arbiter.
package apb_req_arbiter_pkg;

  // Encodings understood by the APB master's add_i command input
  localparam logic [1:0] APB_CMD_IDLE  = 2'b00;
  localparam logic [1:0] APB_CMD_READ  = 2'b01;
  localparam logic [1:0] APB_CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_RESP
  } arb_state_e;

  // Width of an index able to address n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and master-side signals around the arbiter.
// The slave modport is the arbiter's view, master is the surrounding system.
interface apb_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  import apb_req_arbiter_pkg::*;

  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    req_write_i;
  logic [NREQ*DW-1:0] req_wdata_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic               err_o;
  logic [DW-1:0]      rdata_o;
  logic               busy_o;
  logic [1:0]         m_cmd_o;
  logic [DW-1:0]      m_wdata_o;
  logic               m_ready_i;
  logic [DW-1:0]      m_rdata_i;

  modport slave (
    input  req_i, req_write_i, req_wdata_i, m_ready_i, m_rdata_i,
    output gnt_o, done_o, err_o, rdata_o, busy_o, m_cmd_o, m_wdata_o
  );

  modport master (
    output req_i, req_write_i, req_wdata_i, m_ready_i, m_rdata_i,
    input  gnt_o, done_o, err_o, rdata_o, busy_o, m_cmd_o, m_wdata_o
  );

endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around modulo NREQ.
module apb_req_arbiter_rr_pick
  import apb_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan NREQ positions starting at ptr and keep the first one requesting
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NREQ
// requesters, with a watchdog that aborts transfers the master never finishes.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input logic               pclk,
  input logic               preset_n,
  apb_req_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  apb_req_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state logic: arbitrate in IDLE, hold the command in XFER until the
  // master is ready or the watchdog fires, then one RESP cycle for done/err
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          cmd_d   = bus.req_write_i[pick_idx] ? APB_CMD_WRITE : APB_CMD_READ;
          wdata_d = bus.req_wdata_i[int'(pick_idx)*DW +: DW];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.m_ready_i) begin
          if (cmd_q == APB_CMD_READ) rdata_d = bus.m_rdata_i;
          cmd_d   = APB_CMD_IDLE;
          done_d  = NREQ'(1) << idx_q;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cmd_d   = APB_CMD_IDLE;
          done_d  = NREQ'(1) << idx_q;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        done_d  = '0;
        err_d   = 1'b0;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, even mid-transfer
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cmd_q   <= APB_CMD_IDLE;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.busy_o    = busy_q;
  assign bus.m_cmd_o   = cmd_q;
  assign bus.m_wdata_o = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: a transaction-level timeline model
// predicts grants and completions; a negedge monitor compares them.
module tb_apb_req_arbiter;
  import apb_req_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  apb_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  apb_req_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  // Count of rising edges seen so far
  int edge_cnt = 0;
  always @(posedge pclk) edge_cnt <= edge_cnt + 1;

  typedef struct {int at; int w; logic [1:0] cmd; logic [DW-1:0] wdata;} cmd_t;
  typedef struct {int at; int w; bit err; logic [DW-1:0] rdata;} done_t;
  typedef struct {int at; bit busy; bit cmd_on; bit rst;} cyc_t;

  cmd_t  exp_cmd[$];
  done_t exp_done[$];
  cyc_t  exp_cyc[$];

  int tests = 0;
  int fails = 0;

  // Reference model state (timeline of transfers, not of FSM states)
  int ptr = 0, free_at = 0, start_e = -10, done_e = -10, ready_e = -10, cur_w = 0;
  bit pend [NREQ];
  bit pwr [NREQ];
  logic [DW-1:0] pdat [NREQ];
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] xfer_rdata = '0;
  logic [DW-1:0] forced_rdata = '0;
  bit use_forced_rdata = 0;
  int forced_delay = -1;
  bit hold_mode = 0;
  bit random_mode = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Predict what happens at the next edge, drive inputs for it, then advance
  task automatic applyStimulus(input bit rst);
    int e, w, d, dur;
    bit err, in_xfer;
    logic [DW-1:0] exp_rd;
    cmd_t ct;
    done_t dt;
    cyc_t cy;
    done_t keep[$];
    e = edge_cnt + 1;
    if (!hold_mode && e == done_e + 1) pend[cur_w] = 0;
    if (random_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1;
          pwr[i]  = 1'($urandom_range(1));
          pdat[i] = $urandom;
        end
      end
    end
    if (rst) begin
      ptr = 0; free_at = e + 1; start_e = -10; done_e = -10; ready_e = -10; last_rd = '0;
      foreach (exp_done[j]) if (exp_done[j].at < e) keep.push_back(exp_done[j]);
      exp_done = keep;
    end else if (e >= free_at) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (ptr + k) % NREQ;
        if (w < 0 && pend[c]) w = c;
      end
      if (w >= 0) begin
        d = (forced_delay >= 0) ? forced_delay : int'($urandom_range(TIMEOUT + 3, 1));
        xfer_rdata = use_forced_rdata ? forced_rdata : $urandom;
        err = (d > TIMEOUT);
        dur = err ? TIMEOUT : d;
        exp_rd = err ? '0 : (pwr[w] ? last_rd : xfer_rdata);
        last_rd = exp_rd;
        ct.at = e; ct.w = w; ct.cmd = pwr[w] ? APB_CMD_WRITE : APB_CMD_READ; ct.wdata = pdat[w];
        exp_cmd.push_back(ct);
        dt.at = e + dur; dt.w = w; dt.err = err; dt.rdata = exp_rd;
        exp_done.push_back(dt);
        start_e = e; done_e = e + dur; ready_e = err ? -10 : e + d;
        cur_w = w; ptr = (w + 1) % NREQ; free_at = e + dur + 2;
      end
    end
    cy.at = e; cy.rst = rst;
    cy.busy   = !rst && (start_e <= e) && (e <= done_e);
    cy.cmd_on = !rst && (start_e <= e) && (e < done_e);
    exp_cyc.push_back(cy);
    preset_n = !rst;
    in_xfer = (start_e < e) && (e <= done_e);
    bus.m_ready_i = in_xfer ? (e == ready_e) : 1'($urandom_range(1));
    bus.m_rdata_i = (in_xfer && e == ready_e) ? xfer_rdata : $urandom;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_i[i] = pend[i];
      if (i == cur_w && start_e < e && e <= done_e + 1) begin
        bus.req_write_i[i] = 1'($urandom_range(1));
        bus.req_wdata_i[i*DW +: DW] = $urandom;
      end else if (pend[i]) begin
        bus.req_write_i[i] = pwr[i];
        bus.req_wdata_i[i*DW +: DW] = pdat[i];
      end else begin
        bus.req_write_i[i] = 1'($urandom_range(1));
        bus.req_wdata_i[i*DW +: DW] = $urandom;
      end
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic runCycles(input int n, input bit allow_rst);
    repeat (n) applyStimulus(allow_rst && $urandom_range(499) == 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after every edge
  logic [NREQ-1:0] mon_prev_gnt = '0;
  logic [NREQ-1:0] held_gnt = '0;
  logic [1:0]      held_cmd = '0;
  logic [DW-1:0]   held_wdata = '0;
  initial begin
    int x;
    bit have_c, exp_start, exp_d, start, dseen;
    cyc_t c;
    cmd_t ec;
    done_t ed;
    forever begin
      @(negedge pclk);
      x = edge_cnt;
      have_c = 0;
      if (exp_cyc.size() > 0 && exp_cyc[0].at == x) begin
        c = exp_cyc.pop_front();
        have_c = 1;
        checkOutput("busy", 64'(bus.busy_o), 64'(c.busy));
        checkOutput("cmd_active", 64'(bus.m_cmd_o != APB_CMD_IDLE), 64'(c.cmd_on));
        if (c.rst) begin
          checkOutput("reset_ctl", 64'({bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.m_cmd_o}), 64'(0));
          checkOutput("reset_rdata", 64'(bus.rdata_o), 64'(0));
          checkOutput("reset_wdata", 64'(bus.m_wdata_o), 64'(0));
        end
      end
      start = (bus.gnt_o !== '0) && (mon_prev_gnt === '0);
      exp_start = (exp_cmd.size() > 0) && (exp_cmd[0].at == x);
      if (exp_start) begin
        ec = exp_cmd.pop_front();
        held_gnt = NREQ'(1) << ec.w;
        held_cmd = ec.cmd;
        held_wdata = ec.wdata;
        checkOutput("grant", 64'(bus.gnt_o), 64'(held_gnt));
        checkOutput("cmd", 64'(bus.m_cmd_o), 64'(held_cmd));
        checkOutput("wdata", 64'(bus.m_wdata_o), 64'(held_wdata));
      end else if (start) begin
        checkOutput("unexpected_grant", 64'(bus.gnt_o), 64'(0));
      end else if (have_c && c.busy) begin
        checkOutput("gnt_hold", 64'(bus.gnt_o), 64'(held_gnt));
        if (c.cmd_on) begin
          checkOutput("cmd_hold", 64'(bus.m_cmd_o), 64'(held_cmd));
          checkOutput("wdata_hold", 64'(bus.m_wdata_o), 64'(held_wdata));
        end
      end
      dseen = (bus.done_o !== '0);
      exp_d = (exp_done.size() > 0) && (exp_done[0].at == x);
      if (exp_d) begin
        ed = exp_done.pop_front();
        checkOutput("done", 64'(bus.done_o), 64'(NREQ'(1) << ed.w));
        checkOutput("err", 64'(bus.err_o), 64'(ed.err));
        checkOutput("rdata", 64'(bus.rdata_o), 64'(ed.rdata));
        checkOutput("cmd_after_done", 64'(bus.m_cmd_o), 64'(APB_CMD_IDLE));
      end else if (dseen) begin
        checkOutput("unexpected_done", 64'(bus.done_o), 64'(0));
      end
      mon_prev_gnt = bus.gnt_o;
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pwr[i] = 0; pdat[i] = '0; end
    bus.req_i = '0; bus.req_write_i = '0; bus.req_wdata_i = '0;
    bus.m_ready_i = 1'b0; bus.m_rdata_i = '0;
    repeat (2) applyStimulus(1);

    // Single write from requester 0, master ready two cycles after the command
    pend[0] = 1; pwr[0] = 1; pdat[0] = 32'h1234ABCD; forced_delay = 2;
    runCycles(8, 0);

    // Requester 2 reads back the same value
    pend[2] = 1; pwr[2] = 0; use_forced_rdata = 1; forced_rdata = 32'h1234ABCD; forced_delay = 3;
    runCycles(8, 0);

    // Contention from reset: 0,1,3 hold their reads, expect 0,1,3,0,1,3
    applyStimulus(1);
    hold_mode = 1; forced_delay = 1; forced_rdata = 32'h5A5A0001;
    pend[0] = 1; pend[1] = 1; pend[3] = 1; pwr[0] = 0; pwr[1] = 0; pwr[3] = 0;
    runCycles(18, 0);
    hold_mode = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    runCycles(6, 0);

    // Master never ready: watchdog abort
    pend[1] = 1; pwr[1] = 0; forced_delay = TIMEOUT + 4;
    runCycles(TIMEOUT + 6, 0);

    // Ready arrives exactly on the final watchdog count: ready wins
    pend[3] = 1; pwr[3] = 0; forced_rdata = 32'hCAFEF00D; forced_delay = TIMEOUT;
    runCycles(TIMEOUT + 6, 0);

    // Reset in the middle of a write, then requester 1 alone
    pend[0] = 1; pwr[0] = 1; pdat[0] = 32'hDEADBEEF; forced_delay = TIMEOUT + 4;
    runCycles(3, 0);
    pend[0] = 0;
    applyStimulus(1);
    pend[1] = 1; pwr[1] = 0; forced_rdata = 32'h0BADCAFE; forced_delay = 2;
    runCycles(8, 0);

    // Randomized traffic with occasional resets
    forced_delay = -1; use_forced_rdata = 0; random_mode = 1;
    runCycles(3000, 1);

    // Let outstanding requests finish
    random_mode = 0;
    guard = 0;
    while ((exp_cmd.size() > 0 || exp_done.size() > 0 || pend.or() != 0) && guard < 200) begin
      applyStimulus(0);
      guard++;
    end
    runCycles(3, 0);
    @(negedge pclk);
    #1;
    checkOutput("drain_cmd", 64'(exp_cmd.size()), 64'(0));
    checkOutput("drain_done", 64'(exp_done.size()), 64'(0));
    checkOutput("drain_cyc", 64'(exp_cyc.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
